// File: rtl/mod_inverse_unit_if.sv
// Start/done handshake and operand/result bus for mod_inverse_unit.
interface mod_inverse_unit_if #(
  parameter int unsigned WIDTH = 512
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] m;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  modport master (output start, mode, a, m, input busy, done, err, result);
  modport slave  (input start, mode, a, m, output busy, done, err, result);
endinterface

// File: rtl/mod_inverse_unit.sv
// Modular inverse engine: binary extended Euclid (mode 0) or bit-serial
// Montgomery constant n0' = -m^-1 mod 2^N0_W (mode 1).
module mod_inverse_unit #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned N0_W  = 32
) (
  input logic               clk,
  input logic               rst,
  mod_inverse_unit_if.slave bus
);

  localparam int unsigned IW = (N0_W > 1) ? $clog2(N0_W) : 1;

  typedef enum logic [2:0] {IDLE, INIT, RUN_INV, RUN_N0, FIN} state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [WIDTH-1:0]  m_q, m_d;
  logic [WIDTH-1:0]  u_q, u_d, v_q, v_d;
  logic [WIDTH-1:0]  x1_q, x1_d, x2_q, x2_d;
  logic [N0_W-1:0]   x_q, x_d, r_q, r_d;
  logic [IW-1:0]     i_q, i_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              rerr_q, rerr_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [N0_W-1:0]   x_new, r_new, neg;

  // x/2 mod md for odd md, with the carry kept in the extra bit
  function automatic logic [WIDTH-1:0] halve_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] md);
    logic [WIDTH:0] s;
    s = {1'b0, x} + (x[0] ? {1'b0, md} : '0);
    return s[WIDTH:1];
  endfunction

  // (x - y) mod md for x, y in [0, md-1]
  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] md);
    return x - y + ((x < y) ? md : '0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      m_q      <= '0;
      u_q      <= '0;
      v_q      <= '0;
      x1_q     <= '0;
      x2_q     <= '0;
      x_q      <= '0;
      r_q      <= '0;
      i_q      <= '0;
      res_q    <= '0;
      rerr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      m_q      <= m_d;
      u_q      <= u_d;
      v_q      <= v_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      x_q      <= x_d;
      r_q      <= r_d;
      i_q      <= i_d;
      res_q    <= res_d;
      rerr_q   <= rerr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    m_d      = m_q;
    u_d      = u_q;
    v_d      = v_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    x_d      = x_q;
    r_d      = r_q;
    i_d      = i_q;
    res_d    = res_q;
    rerr_d   = rerr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    x_new    = x_q;
    r_new    = r_q;
    neg      = '0;

    case (state_q)
      IDLE: begin
        // u/v double as the latched a/m until INIT decides what to do
        if (bus.start) begin
          state_d = INIT;
          busy_d  = 1'b1;
          mode_d  = bus.mode;
          u_d     = bus.a;
          v_d     = bus.m;
          m_d     = bus.m;
        end
      end

      INIT: begin
        x1_d   = WIDTH'(1);
        x2_d   = '0;
        x_d    = N0_W'(1);
        r_d    = m_q[N0_W-1:0];
        i_d    = IW'(1);
        rerr_d = 1'b0;
        res_d  = '0;
        if (!mode_q) begin
          if (!m_q[0] || (m_q < WIDTH'(3)) || (u_q == '0) || (u_q >= m_q)) begin
            rerr_d  = 1'b1;
            state_d = FIN;
          end else if (u_q == WIDTH'(1)) begin
            res_d   = WIDTH'(1);
            state_d = FIN;
          end else begin
            state_d = RUN_INV;
          end
        end else begin
          if (!m_q[0]) begin
            rerr_d  = 1'b1;
            state_d = FIN;
          end else if (N0_W == 1) begin
            res_d   = WIDTH'(1);
            state_d = FIN;
          end else begin
            state_d = RUN_N0;
          end
        end
      end

      RUN_INV: begin
        // invariants: a*x1 == u, a*x2 == v (mod m)
        if (u_q == WIDTH'(1)) begin
          res_d   = x1_q;
          state_d = FIN;
        end else if (v_q == WIDTH'(1)) begin
          res_d   = x2_q;
          state_d = FIN;
        end else if ((u_q == '0) || (v_q == '0)) begin
          rerr_d  = 1'b1;
          res_d   = '0;
          state_d = FIN;
        end else if (!u_q[0]) begin
          u_d  = u_q >> 1;
          x1_d = halve_mod(x1_q, m_q);
        end else if (!v_q[0]) begin
          v_d  = v_q >> 1;
          x2_d = halve_mod(x2_q, m_q);
        end else if (u_q >= v_q) begin
          u_d  = u_q - v_q;
          x1_d = sub_mod(x1_q, x2_q, m_q);
        end else begin
          v_d  = v_q - u_q;
          x2_d = sub_mod(x2_q, x1_q, m_q);
        end
      end

      RUN_N0: begin
        // r tracks m*x mod 2^N0_W; clearing bit i fixes bit i of x
        if (r_q[i_q]) begin
          x_new = x_q | (N0_W'(1) << i_q);
          r_new = r_q + (m_q[N0_W-1:0] << i_q);
        end
        x_d = x_new;
        r_d = r_new;
        i_d = i_q + IW'(1);
        if (i_q == IW'(N0_W - 1)) begin
          neg     = '0 - x_new;
          res_d   = WIDTH'(neg);
          state_d = FIN;
        end
      end

      FIN: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        err_d    = rerr_q;
        result_d = res_q;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;

endmodule
